// File: rtl/monitor_pkg.sv
// Shared definitions for the monitor port: TX state encoding, bus addresses
// and the parity helper used by the device-side transmitter.
package monitor_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } txState_e;

  localparam logic [31:0] DEVICE_ADDRESS = 32'h0000FFF8;
  localparam logic [31:0] STATUS_ADDRESS = 32'h0000FFFC;

  function automatic logic evenParity(input logic [7:0] dataByte);
    return ^dataByte;
  endfunction

endpackage

// File: rtl/monitor_baud_tick.sv
// Bit-period counter for the monitor TX path: raises tick on the last cycle
// of each CLKS_PER_BIT-long serial bit; cleared when a new frame starts.
module monitor_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] count_r;

  // Count clock cycles within the current bit, wrapping at the bit boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      if (count_r == LAST_COUNT) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + ONE;
      end
    end else begin
      count_r <= '0;
    end
  end

  assign tick = enable && (count_r == LAST_COUNT);

endmodule

// File: rtl/monitor_tx_device.sv
// Device end of the monitor port: serializes a written word as UART bytes,
// LSB first. Define MONITOR_TX_PARITY_EN to add an even-parity bit per byte.
module monitor_tx_device
  import monitor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int BYTES        = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        deviceWrite,
  input  logic [31:0] dataDeviceIn,
  output logic        tx,
  output logic        busy,
  output logic        dataDeviceFinish,
  output logic        overrun
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES - 1);

  txState_e    state_r;
  logic [31:0] shiftReg_r;
  logic [2:0]  bitIdx_r;
  logic [1:0]  byteIdx_r;
  logic        tx_r;
  logic        busy_r;
  logic        finish_r;
  logic        overrun_r;

  logic        idleLike_s;
  logic        frameStart_s;
  logic        counterEn_s;
  logic        bitTick_s;
  logic [7:0]  curByte_s;

  // DONE counts as idle so a write there chains straight into the next word.
  always_comb begin
    idleLike_s   = (state_r == IDLE) || (state_r == DONE);
    frameStart_s = deviceWrite && idleLike_s;
    counterEn_s  = !idleLike_s;
    curByte_s    = shiftReg_r[7:0];
  end

  monitor_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baudTick (
    .clock (clock),
    .reset (reset),
    .clear (frameStart_s),
    .enable(counterEn_s),
    .tick  (bitTick_s)
  );

  // Frame sequencer; pins are registered from the current state, so they
  // trail the state by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      shiftReg_r <= 32'd0;
      bitIdx_r   <= 3'd0;
      byteIdx_r  <= 2'd0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      finish_r   <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      if (deviceWrite && !idleLike_s) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        IDLE, DONE: begin
          tx_r     <= 1'b1;
          busy_r   <= 1'b0;
          finish_r <= (state_r == DONE);
          if (deviceWrite) begin
            shiftReg_r <= dataDeviceIn;
            bitIdx_r   <= 3'd0;
            byteIdx_r  <= 2'd0;
            state_r    <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          tx_r     <= 1'b0;
          busy_r   <= 1'b1;
          finish_r <= 1'b0;
          if (bitTick_s) begin
            bitIdx_r <= 3'd0;
            state_r  <= DATA;
          end
        end
        DATA: begin
          tx_r     <= curByte_s[bitIdx_r];
          busy_r   <= 1'b1;
          finish_r <= 1'b0;
          if (bitTick_s) begin
            if (bitIdx_r == 3'd7) begin
              bitIdx_r <= 3'd0;
`ifdef MONITOR_TX_PARITY_EN
              state_r  <= PARITY;
`else
              state_r  <= STOP;
`endif
            end else begin
              bitIdx_r <= bitIdx_r + 3'd1;
            end
          end
        end
`ifdef MONITOR_TX_PARITY_EN
        PARITY: begin
          tx_r     <= evenParity(curByte_s);
          busy_r   <= 1'b1;
          finish_r <= 1'b0;
          if (bitTick_s) begin
            state_r <= STOP;
          end
        end
`endif
        STOP: begin
          tx_r     <= 1'b1;
          busy_r   <= 1'b1;
          finish_r <= 1'b0;
          if (bitTick_s) begin
            if (byteIdx_r != LAST_BYTE) begin
              byteIdx_r  <= byteIdx_r + 2'd1;
              shiftReg_r <= {8'd0, shiftReg_r[31:8]};
              state_r    <= START;
            end else begin
              state_r <= DONE;
            end
          end
        end
        default: begin
          tx_r     <= 1'b1;
          busy_r   <= 1'b0;
          finish_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign tx               = tx_r;
  assign busy             = busy_r;
  assign dataDeviceFinish = finish_r;
  assign overrun          = overrun_r;

endmodule

// File: doc/monitor_tx_device.md
Name: monitor_tx_device

Overview:
- Device-side end of the memory-mapped monitor port.
- Accepts the 32-bit word the monitor interface forwards on a device write and serializes it as a UART stream, bytes LSB-first.
- Pulses a one-cycle finish strobe so the interface can clear the status word.
- Sits between the monitor interface and the board TX pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); must be >= 2
BYTES, 4, bytes per word sent, 1..4, starting at byte 0 (bits 7:0)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
deviceWrite  input  1  one-cycle strobe: new word present on dataDeviceIn
dataDeviceIn  input  32  word to transmit; sampled only on an accepted deviceWrite
tx  output  1  serial line, idle high
busy  output  1  high while a word is being transmitted
dataDeviceFinish  output  1  one-cycle pulse when the last stop bit completes
overrun  output  1  sticky: deviceWrite arrived while busy

Behaviour:
- Reset (sync, any state): tx=1, busy=0, dataDeviceFinish=0, overrun=0, state=IDLE, all counters 0. Mid-frame reset aborts the frame with no finish pulse.
- States: IDLE, START, DATA, STOP, DONE.
- IDLE/DONE accept: deviceWrite=1 latches dataDeviceIn into a shift register. Next state START. busy=1 and tx=0 from the following edge.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - If byte index < BYTES-1: increment byte index, shift register right 8, go to START.
  - Otherwise go to DONE.
- DONE: lasts exactly one cycle. dataDeviceFinish=1, busy=0, tx=1. Next state IDLE, or START if deviceWrite=1 in this cycle.
- Timing: with deviceWrite sampled at edge 0, dataDeviceFinish is high during the cycle after edge 1+BYTES*10*CLKS_PER_BIT (no parity).
- Bit counter: 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary. Width is $clog2(CLKS_PER_BIT).
- Busy write: deviceWrite while busy=1 is ignored and sets overrun=1. The frame in flight is unaffected. overrun clears only on reset.
- DONE has busy=0, so a write in DONE is accepted, not an overrun.
- dataDeviceIn changing outside an accepted strobe has no effect.

Optional Feature:
- Macro: MONITOR_TX_PARITY_EN.
- Defined: a PARITY state between DATA and STOP transmits even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame becomes 11 bits per byte; finish timing uses 11 instead of 10.
- Undefined: no PARITY state and no parity logic; frame is 10 bits.

Decomposition:
- Shared package monitor_pkg:
  - state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, DONE=5)
  - DEVICE_ADDRESS 32'h0000FFF8 and STATUS_ADDRESS 32'h0000FFFC, shared with the monitor interface
- One natural sub-module: monitor_baud_tick, the CLKS_PER_BIT counter producing a bit-end tick, cleared on frame start.

Test Plan (CLKS_PER_BIT=4, BYTES=4):
- Reset, no stimulus -> tx=1, busy=0, dataDeviceFinish=0, overrun=0 for 100 cycles.
- deviceWrite with 32'h12345678 -> bytes 78,56,34,12 on tx, each 0+LSB-first data+1, 4 cycles per bit. busy high 160 cycles. dataDeviceFinish single-cycle pulse at edge 161.
- deviceWrite with 32'hA5 mid-byte-1 of a running frame -> overrun=1, transmitted bytes unchanged, one finish pulse.
- deviceWrite held high in the DONE cycle with 32'hFFFFFFFF -> tx falls next edge, no idle gap, busy stays low only that one cycle, overrun stays 0.
- reset asserted during byte 2 data bits -> next edge tx=1, busy=0, no dataDeviceFinish. A later write transmits normally from byte 0.
- MONITOR_TX_PARITY_EN defined, word 32'h00000103 -> parity bits 0,1,0,0. Finish at edge 177.
